sdram_line_cache: RTL and testbench
===================================

// Module: sdram_line_cache
// PURPOSE
//  Direct-mapped read cache of 64-bit lines (4 x 16-bit words) in front of the 128MHz SDRAM controller.
//  - Hit: served locally. Miss: issues one 4-word burst read and stores the returned 64-bit line.
//  - CPU writes go to SDRAM directly; this block only snoops them to keep cached lines coherent.
//  - Sits upstream of the SDRAM controller (drives its oe/addr) and consumes its 64-bit dout.
// PARAMETERS
//  LINES  16  number of cache lines; power of two, >=2; IDX = log2(LINES)
//  AW     24  word-address width
// PORTS
//  clk_128   in   1   128MHz clock, same clock as the SDRAM controller
//  reset_n   in   1   asynchronous, active-low reset
//  flush     in   1   invalidate all lines (level, sampled in IDLE)
//  cpu_addr  in   AW  word address
//  cpu_rd    in   1   read request; level, held until cpu_ack
//  cpu_wr    in   1   write snoop; single-cycle pulse
//  cpu_din   in   16  write data
//  cpu_ds    in   2   byte strobes: [1]=bits 15:8, [0]=bits 7:0
//  cpu_dout  out  16  read data; valid in cpu_ack cycle, held until the next ack
//  cpu_ack   out  1   one-cycle read-complete pulse
//  busy      out  1   high in every state except IDLE
//  mem_oe    out  1   burst read request to the SDRAM controller
//  mem_addr  out  AW  line-aligned address; [1:0]=0
//  mem_dout  in   64  line from SDRAM; slot i = word with addr[1:0]=i
//  mem_done  in   1   one-cycle pulse; mem_dout is valid in this cycle
// BEHAVIOUR
//  Address split: word=addr[1:0], index=addr[2+IDX-1:2], tag=addr[AW-1:2+IDX].
//  Storage: data/tag/valid arrays held in registers with combinational read.
//  Reset values: state=IDLE; all valid bits=0; cpu_ack=0, cpu_dout=0, mem_oe=0, mem_addr=0, busy=0.
//  Reset mid-FILL: mem_oe drops immediately.
//  FSM:
//   IDLE   priority flush > cpu_wr > cpu_rd.
//          flush  -> FLUSH.
//          cpu_wr -> on valid tag match, merge cpu_din into the addressed word per cpu_ds; stay IDLE.
//          cpu_rd -> latch addr -> LOOKUP.
//   LOOKUP hit  -> cpu_dout = stored word, cpu_ack=1 -> IDLE. Read-hit latency: ack 2 cycles after cpu_rd is sampled.
//          miss -> mem_oe=1, mem_addr={addr[AW-1:2],2'b00} -> FILL.
//   FILL   hold mem_oe and mem_addr until mem_done.
//          On mem_done: write line, tag, valid=1; latch mem_dout[16*word +: 16] into cpu_dout; mem_oe=0 next cycle -> RESP.
//   RESP   cpu_ack=1 -> IDLE.
//   FLUSH  clear one valid bit per cycle, index 0..LINES-1 (LINES cycles) -> IDLE. Requests wait.
//  Protocol rules:
//   - cpu_wr is honoured only in IDLE; cpu_wr in any other state is ignored (CPU is stalled by busy).
//   - cpu_rd and cpu_wr in the same IDLE cycle: write is taken first, read the next cycle.
//   - Ignore mem_done outside FILL.
//   - mem_dout is consumed only in the mem_done cycle.
//   - cpu_rd dropped before ack: the cycle in progress completes, and the line is still filled.
//   - cpu_ack never asserts in two consecutive cycles.
//  Tag compare: full tag width. Two addresses differing only in tag evict each other (no replacement policy).
// TESTING
//  1 Cold read 0x000005 -> mem_oe=1, mem_addr=0x000004; mem_done, mem_dout=0x4444_3333_2222_1111 -> cpu_ack, cpu_dout=0x2222.
//  2 Read 0x000006 after test 1 -> hit: no mem_oe, cpu_dout=0x3333, ack 2 cycles after cpu_rd.
//  3 cpu_wr 0x000006, din=0xABCD, ds=2'b10 -> next read 0x000006 returns 0xAB33 with no SDRAM access.
//  4 Conflict (LINES=16): read 0x000044 evicts 0x000004 -> a later read 0x000005 misses again.
//  5 flush pulse -> busy for 16 cycles; a read of any previously cached line then misses.
//  6 reset_n low while in FILL with mem_oe=1 -> mem_oe=0 at once; after release, read 0x000005 misses.

Source files
------------

// File: rtl/sdram_line_cache.sv
// Direct-mapped read cache of 64-bit SDRAM lines (4 x 16-bit words).
// Misses fetch one burst line from the controller; CPU writes are snooped so cached lines stay coherent.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accept flush > write snoop > read request
// LOOKUP | compare the latched address against the tag/valid arrays
// FILL   | burst read outstanding, mem_oe held until mem_done
// RESP   | filled word already in cpu_dout, pulse cpu_ack
// FLUSH  | clear one valid bit per cycle, index 0 upward
module sdram_line_cache #(
   parameter int LINES = 16,
   parameter int AW    = 24
) (
   input  logic          clk_128,
   input  logic          reset_n,
   input  logic          flush,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [15:0]   cpu_din,
   input  logic [1:0]    cpu_ds,
   output logic [15:0]   cpu_dout,
   output logic          cpu_ack,
   output logic          busy,
   output logic          mem_oe,
   output logic [AW-1:0] mem_addr,
   input  logic [63:0]   mem_dout,
   input  logic          mem_done
);

   localparam int IDX = $clog2(LINES);
   localparam int TW  = AW - 2 - IDX;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_FILL   = 3'd2,
      S_RESP   = 3'd3,
      S_FLUSH  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [63:0]      data_q [LINES];
   logic [TW-1:0]    tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   logic [AW-1:0]  addr_q;
   logic [IDX-1:0] flush_cnt_q;
   logic [15:0]    cpu_dout_q;
   logic           cpu_ack_q;
   logic           mem_oe_q;
   logic [AW-1:0]  mem_addr_q;

   logic [1:0]     cpu_word, lk_word;
   logic [IDX-1:0] cpu_idx, lk_idx;
   logic [TW-1:0]  cpu_tag, lk_tag;
   logic           lk_hit, wr_match;
   logic [15:0]    lk_data, fill_data, snoop_old, snoop_new;

   logic           take_rd, snoop_we, ack_d, dout_we, start_fill, fill_we;
   logic           flush_start, flush_clr;
   logic [15:0]    dout_d;

   assign cpu_word = cpu_addr[1:0];
   assign cpu_idx  = cpu_addr[2 +: IDX];
   assign cpu_tag  = cpu_addr[AW-1 -: TW];
   assign lk_word  = addr_q[1:0];
   assign lk_idx   = addr_q[2 +: IDX];
   assign lk_tag   = addr_q[AW-1 -: TW];

   assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign wr_match  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign lk_data   = data_q[lk_idx][{lk_word, 4'b0000} +: 16];
   assign fill_data = mem_dout[{lk_word, 4'b0000} +: 16];
   assign snoop_old = data_q[cpu_idx][{cpu_word, 4'b0000} +: 16];
   assign snoop_new = {cpu_ds[1] ? cpu_din[15:8] : snoop_old[15:8],
                       cpu_ds[0] ? cpu_din[7:0]  : snoop_old[7:0]};

   always_ff @(posedge clk_128 or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      take_rd     = 1'b0;
      snoop_we    = 1'b0;
      ack_d       = 1'b0;
      dout_we     = 1'b0;
      dout_d      = cpu_dout_q;
      start_fill  = 1'b0;
      fill_we     = 1'b0;
      flush_start = 1'b0;
      flush_clr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               flush_start = 1'b1;
               state_d     = S_FLUSH;
            end else if (cpu_wr) begin
               snoop_we = wr_match;
            end else if (cpu_rd && !cpu_ack_q) begin
               // the ack cycle is skipped so a still-held cpu_rd is not re-served
               take_rd = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (lk_hit) begin
               ack_d   = 1'b1;
               dout_we = 1'b1;
               dout_d  = lk_data;
               state_d = S_IDLE;
            end else begin
               start_fill = 1'b1;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_done) begin
               fill_we = 1'b1;
               dout_we = 1'b1;
               dout_d  = fill_data;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            ack_d   = 1'b1;
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            flush_clr = 1'b1;
            if (flush_cnt_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_128 or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         flush_cnt_q <= '0;
         cpu_dout_q  <= '0;
         cpu_ack_q   <= 1'b0;
         mem_oe_q    <= 1'b0;
         mem_addr_q  <= '0;
         valid_q     <= '0;
      end else begin
         cpu_ack_q <= ack_d;
         if (take_rd) addr_q <= cpu_addr;
         if (dout_we) cpu_dout_q <= dout_d;
         if (start_fill) begin
            mem_oe_q   <= 1'b1;
            mem_addr_q <= {addr_q[AW-1:2], 2'b00};
         end else if (fill_we) begin
            mem_oe_q <= 1'b0;
         end
         // down-counter walks the index upward through its complement
         if (flush_start)    flush_cnt_q <= IDX'(LINES - 1);
         else if (flush_clr) flush_cnt_q <= flush_cnt_q - IDX'(1);
         if (flush_clr)      valid_q[~flush_cnt_q] <= 1'b0;
         else if (fill_we)   valid_q[lk_idx]       <= 1'b1;
      end
   end

   always_ff @(posedge clk_128) begin
      if (fill_we) begin
         data_q[lk_idx] <= mem_dout;
         tag_q[lk_idx]  <= lk_tag;
      end else if (snoop_we) begin
         data_q[cpu_idx][{cpu_word, 4'b0000} +: 16] <= snoop_new;
      end
   end

   assign cpu_dout = cpu_dout_q;
   assign cpu_ack  = cpu_ack_q;
   assign mem_oe   = mem_oe_q;
   assign mem_addr = mem_addr_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_line_cache.sv
// Bench for sdram_line_cache: directed vector table, hand-written corner sequences,
// and random reads/writes/flushes checked against a backing-store plus hit/miss model.
module tb_sdram_line_cache;

   localparam int LINES = 16;
   localparam int AW    = 24;

   logic          clk_128 = 1'b0;
   logic          reset_n;
   logic          flush;
   logic [AW-1:0] cpu_addr;
   logic          cpu_rd;
   logic          cpu_wr;
   logic [15:0]   cpu_din;
   logic [1:0]    cpu_ds;
   logic [15:0]   cpu_dout;
   logic          cpu_ack;
   logic          busy;
   logic          mem_oe;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_dout, resp_dout, stray_dout;
   logic          mem_done, resp_done, stray_done;

   assign mem_done = resp_done | stray_done;
   assign mem_dout = stray_done ? stray_dout : resp_dout;

   sdram_line_cache #(.LINES(LINES), .AW(AW)) dut (
      .clk_128 (clk_128),
      .reset_n (reset_n),
      .flush   (flush),
      .cpu_addr(cpu_addr),
      .cpu_rd  (cpu_rd),
      .cpu_wr  (cpu_wr),
      .cpu_din (cpu_din),
      .cpu_ds  (cpu_ds),
      .cpu_dout(cpu_dout),
      .cpu_ack (cpu_ack),
      .busy    (busy),
      .mem_oe  (mem_oe),
      .mem_addr(mem_addr),
      .mem_dout(mem_dout),
      .mem_done(mem_done)
   );

   always #5 clk_128 = ~clk_128;

   int          passed = 0;
   int          total  = 0;
   int          fills  = 0;
   int          ack2   = 0;
   logic [23:0] fill_addr = '0;
   bit          auto_resp = 1'b1;
   bit          p_oe = 1'b0;
   bit          p_ack = 1'b0;

   // backing SDRAM contents; untouched words follow a fixed formula
   logic [15:0] smem [int];
   // reference cache: only which line each index holds matters, data is always the SDRAM value
   bit          ref_valid [LINES];
   logic [17:0] ref_tag   [LINES];

   typedef struct {
      bit          is_wr;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  ds;
      logic [15:0] exp_data;
      bit          exp_hit;
   } vec_t;

   vec_t vt [12];

   function automatic logic [15:0] dflt(input logic [23:0] a);
      return a[15:0] * 16'h03b1 + 16'h001d;
   endfunction

   function automatic logic [15:0] rdw(input logic [23:0] a);
      int k;
      k = int'(a);
      if (smem.exists(k)) return smem[k];
      return dflt(a);
   endfunction

   function automatic bit model_hit(input logic [23:0] a);
      return ref_valid[int'(a[5:2])] && (ref_tag[int'(a[5:2])] == a[23:6]);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   // SDRAM controller stand-in: random latency, garbage on mem_dout outside the done cycle
   initial begin
      int          cd;
      logic [23:0] la;
      cd = -1;
      la = '0;
      resp_done = 1'b0;
      resp_dout = '0;
      forever begin
         @(posedge clk_128); #1;
         resp_done = 1'b0;
         if (cd > 0) begin
            cd--;
         end else if (cd == 0) begin
            resp_dout = {rdw(la + 24'd3), rdw(la + 24'd2), rdw(la + 24'd1), rdw(la)};
            resp_done = 1'b1;
            cd = -1;
         end else begin
            resp_dout = {$urandom, $urandom};
            if (auto_resp && mem_oe) begin
               la = mem_addr;
               cd = $urandom_range(0, 3);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_128);
         if (mem_oe && !p_oe) begin
            fills++;
            fill_addr = mem_addr;
         end
         if (cpu_ack && p_ack) ack2++;
         p_oe  = mem_oe;
         p_ack = cpu_ack;
      end
   end

   task automatic do_read(input logic [23:0] a, output logic [15:0] d, output int lat, output bit ok);
      d   = '0;
      ok  = 1'b0;
      lat = 0;
      @(posedge clk_128); #1;
      cpu_addr = a;
      cpu_rd   = 1'b1;
      while (!ok && lat < 100) begin
         @(posedge clk_128); #1;
         lat++;
         if (cpu_ack) begin
            ok = 1'b1;
            d  = cpu_dout;
         end
      end
      cpu_rd = 1'b0;
   endtask

   task automatic check_read(input logic [23:0] a, input logic [15:0] exp_d, input bit exp_hit,
                             input string nm);
      int          f0;
      int          lat;
      bit          ok;
      logic [15:0] d;
      f0 = fills;
      do_read(a, d, lat, ok);
      chk({nm, "_ack"}, 32'(ok), 32'd1);
      chk({nm, "_data"}, 32'(d), 32'(exp_d));
      chk({nm, "_sdram_access"}, 32'(fills - f0), 32'(exp_hit ? 0 : 1));
      if (exp_hit) chk({nm, "_latency"}, 32'(lat), 32'd2);
      else         chk({nm, "_mem_addr"}, 32'(fill_addr), 32'({a[23:2], 2'b00}));
      ref_valid[int'(a[5:2])] = 1'b1;
      ref_tag[int'(a[5:2])]   = a[23:6];
   endtask

   task automatic do_write(input logic [23:0] a, input logic [15:0] din, input logic [1:0] ds);
      logic [15:0] o;
      o = rdw(a);
      smem[int'(a)] = {ds[1] ? din[15:8] : o[15:8], ds[0] ? din[7:0] : o[7:0]};
      @(posedge clk_128); #1;
      cpu_addr = a;
      cpu_din  = din;
      cpu_ds   = ds;
      cpu_wr   = 1'b1;
      @(posedge clk_128); #1;
      cpu_wr = 1'b0;
   endtask

   task automatic do_flush();
      int n;
      @(posedge clk_128); #1;
      flush = 1'b1;
      @(posedge clk_128); #1;
      flush = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk_128); #1;
      end
      chk("flush_busy_cycles", 32'(n), 32'd16);
      model_clear();
   endtask

   initial begin
      int          n;
      int          lat;
      bit          ok;
      logic [15:0] d;
      logic [15:0] o;
      logic [23:0] a;
      int          r;

      smem[4] = 16'h1111;
      smem[5] = 16'h2222;
      smem[6] = 16'h3333;
      smem[7] = 16'h4444;

      vt[0]  = '{1'b0, 24'h000005, 16'h0000, 2'b00, 16'h2222,      1'b0};
      vt[1]  = '{1'b0, 24'h000006, 16'h0000, 2'b00, 16'h3333,      1'b1};
      vt[2]  = '{1'b1, 24'h000006, 16'hABCD, 2'b10, 16'h0000,      1'b0};
      vt[3]  = '{1'b0, 24'h000006, 16'h0000, 2'b00, 16'hAB33,      1'b1};
      vt[4]  = '{1'b0, 24'h000044, 16'h0000, 2'b00, dflt(24'h44),  1'b0};
      vt[5]  = '{1'b0, 24'h000005, 16'h0000, 2'b00, 16'h2222,      1'b0};
      vt[6]  = '{1'b0, 24'h000004, 16'h0000, 2'b00, 16'h1111,      1'b1};
      vt[7]  = '{1'b1, 24'h000007, 16'h12EF, 2'b01, 16'h0000,      1'b0};
      vt[8]  = '{1'b0, 24'h000007, 16'h0000, 2'b00, 16'h44EF,      1'b1};
      vt[9]  = '{1'b1, 24'h000085, 16'h7777, 2'b11, 16'h0000,      1'b0};
      vt[10] = '{1'b0, 24'h000085, 16'h0000, 2'b00, 16'h7777,      1'b0};
      vt[11] = '{1'b0, 24'h000005, 16'h0000, 2'b00, 16'h2222,      1'b0};

      reset_n    = 1'b0;
      flush      = 1'b0;
      cpu_addr   = '0;
      cpu_rd     = 1'b0;
      cpu_wr     = 1'b0;
      cpu_din    = '0;
      cpu_ds     = '0;
      stray_done = 1'b0;
      stray_dout = '0;
      model_clear();

      #23;
      chk("reset_cpu_ack",  32'(cpu_ack),  32'd0);
      chk("reset_cpu_dout", 32'(cpu_dout), 32'd0);
      chk("reset_mem_oe",   32'(mem_oe),   32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_busy",     32'(busy),     32'd0);
      @(posedge clk_128); #1;
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         if (vt[i].is_wr) do_write(vt[i].addr, vt[i].din, vt[i].ds);
         else check_read(vt[i].addr, vt[i].exp_data, vt[i].exp_hit, $sformatf("vec%0d", i));
      end

      // flush: previously cached line must miss afterwards
      check_read(24'h000006, rdw(24'h000006), model_hit(24'h000006), "pre_flush_read");
      do_flush();
      check_read(24'h000006, rdw(24'h000006), 1'b0, "post_flush_read");

      // cpu_rd dropped right after being sampled: fill still completes
      @(posedge clk_128); #1;
      cpu_addr = 24'h000123;
      cpu_rd   = 1'b1;
      @(posedge clk_128); #1;
      cpu_rd = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(posedge clk_128); #1;
      end
      chk("dropped_rd_completes", 32'(busy), 32'd0);
      ref_valid[8] = 1'b1;
      ref_tag[8]   = 18'd4;
      check_read(24'h000122, rdw(24'h000122), 1'b1, "dropped_rd_line_kept");

      // read and write in the same cycle: write first, read one cycle later
      o = rdw(24'h000121);
      smem[int'(24'h000121)] = 16'h5A5A;
      @(posedge clk_128); #1;
      cpu_addr = 24'h000121;
      cpu_din  = 16'h5A5A;
      cpu_ds   = 2'b11;
      cpu_wr   = 1'b1;
      cpu_rd   = 1'b1;
      @(posedge clk_128); #1;
      cpu_wr = 1'b0;
      lat = 1;
      ok  = 1'b0;
      d   = '0;
      while (!ok && lat < 50) begin
         @(posedge clk_128); #1;
         lat++;
         if (cpu_ack) begin
            ok = 1'b1;
            d  = cpu_dout;
         end
      end
      cpu_rd = 1'b0;
      chk("rdwr_same_cycle_ack",     32'(ok),  32'd1);
      chk("rdwr_same_cycle_latency", 32'(lat), 32'd3);
      chk("rdwr_same_cycle_data",    32'(d),   32'h5A5A);
      chk("rdwr_old_word_differs",   32'(o != 16'h5A5A), 32'd1);

      // stray mem_done while idle must not touch the cache
      @(posedge clk_128); #1;
      stray_dout = 64'hDEAD_BEEF_CAFE_F00D;
      stray_done = 1'b1;
      @(posedge clk_128); #1;
      stray_done = 1'b0;
      check_read(24'h000121, rdw(24'h000121), 1'b1, "stray_done_ignored");

      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 99);
         a = 24'($urandom_range(0, 191));
         if (r < 3)       do_flush();
         else if (r < 40) do_write(a, 16'($urandom), 2'($urandom_range(0, 3)));
         else             check_read(a, rdw(a), model_hit(a), "rand");
      end

      // reset while a burst is outstanding
      do_flush();
      auto_resp = 1'b0;
      @(posedge clk_128); #1;
      cpu_addr = 24'h000005;
      cpu_rd   = 1'b1;
      n = 0;
      while (!mem_oe && n < 20) begin
         n++;
         @(posedge clk_128); #1;
      end
      chk("fill_mem_oe_high", 32'(mem_oe), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_in_fill_mem_oe", 32'(mem_oe), 32'd0);
      chk("reset_in_fill_busy",   32'(busy),   32'd0);
      cpu_rd = 1'b0;
      @(posedge clk_128); #1;
      reset_n   = 1'b1;
      auto_resp = 1'b1;
      model_clear();
      check_read(24'h000005, rdw(24'h000005), 1'b0, "post_reset_read");

      chk("no_back_to_back_ack", 32'(ack2), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
